parity_serial_tx: RTL and testbench
===================================

Name: parity_serial_tx

Overview:
- Downstream consumer of the byte-parity generator.
- Accepts an 8-bit word through a valid/ready handshake and computes its parity internally (XOR of all data bits).
- Serializes the frame LSB-first onto a single line: start bit, 8 data bits, parity bit, stop bit.
- Sits between the parallel data path and the serial link pad/driver.

Parameters:
- CLKS_PER_BIT, 4, clk cycles each serial bit is held on tx_out; legal range >= 1; counter width $clog2(CLKS_PER_BIT), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled only on an accepted handshake.
- data_valid  input  1  upstream has a byte on data_in.
- data_ready  output  1  block can accept a byte this cycle.
- tx_out  output  1  serial line; idle level 1.
- tx_busy  output  1  frame in progress.
- frame_done  output  1  single-cycle pulse after the stop bit completes.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, tx_out=1, tx_busy=0, frame_done=0, data_ready=1, shift register=0, counters=0.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered except data_ready = (state==IDLE).
- Handshake:
  - A byte is accepted on the rising edge where data_valid && data_ready.
  - On acceptance: data_in is latched into the shift register, par_bit = ^data_in is latched, and the next state is START.
  - data_valid without data_ready is ignored. Upstream holds data_in and data_valid until accepted.
  - data_in changes after acceptance have no effect on the frame in flight.
- Timing:
  - tx_out drives the start bit (0) from the cycle after acceptance.
  - Every bit is held exactly CLKS_PER_BIT cycles. A bit-cycle counter counts 0..CLKS_PER_BIT-1; the bit advances when the counter hits its terminal count.
- Transitions:
  - START -> DATA.
  - DATA shifts LSB-first: tx_out = shreg[0]. Data bit index 0..7; after index 7 -> PARITY.
  - PARITY: tx_out = par_bit -> STOP.
  - STOP: tx_out = 1 -> IDLE.
- Frame length: 11*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the stop bit.
- tx_busy: 1 from the first start-bit cycle through the last stop-bit cycle, otherwise 0.
- frame_done: high for exactly one cycle, the first IDLE cycle after STOP.
- Back-to-back: a byte may be accepted in the frame_done cycle. Its start bit follows immediately, giving a minimum gap of 1 idle cycle (tx_out=1) between frames.
- Reset mid-frame: the frame is abandoned. The next edge returns all outputs to reset values, and tx_out=1 without completing the frame. No frame_done pulse.
- Reset and data_valid asserted together: reset wins and the byte is not accepted.

Optional Feature:
- Macro: PAR_TX_ODD_PARITY_EN.
- Defined: par_bit = ~(^data_in), i.e. odd parity (total ones across data+parity is odd).
- Undefined (default): par_bit = ^data_in, i.e. even parity, matching the upstream parity generator output.
- No port or timing differences either way.

Test Plan:
- Reset held 3 cycles, data_valid=1 -> tx_out=1, data_ready=1, tx_busy=0, frame_done=0, no byte accepted.
- CLKS_PER_BIT=4, send 0xA5 (even parity) -> tx_out sequence per 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 0 | 1. tx_busy high for 44 cycles, then frame_done pulse for 1 cycle.
- Send 0x07 -> parity bit 1; data bits 1,1,1,0,0,0,0,0. With PAR_TX_ODD_PARITY_EN defined, same byte gives parity bit 0.
- data_valid held high with 0x00 then 0xFF -> second start bit exactly 1 cycle after first stop bit ends. data_ready low throughout each frame; each byte accepted exactly once.
- Assert reset during DATA bit 3 of 0x3C -> tx_out=1 and tx_busy=0 on the next edge, no frame_done. A following 0x3C sends a complete correct frame.
- CLKS_PER_BIT=1, send 0x80 -> 11-cycle frame 0,0,0,0,0,0,0,0,1,1,1 (parity 1, stop 1).

Source files
------------

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start, 8 data bits LSB-first, parity, stop; valid/ready byte intake.
// Optional macro PAR_TX_ODD_PARITY_EN selects odd parity; default is even parity.
module parity_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          tc;
  logic          par_in;

`ifdef PAR_TX_ODD_PARITY_EN
  assign par_in = ~(^data_in);
`else
  assign par_in = ^data_in;
`endif

  assign tc = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Next-state logic; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          shreg_d = data_in;
          par_d   = par_in;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tc) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tc) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tc) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tc) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign tx_out     = tx_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_parity_serial_tx;

  logic       clk;
  logic       reset;
  logic [1:0] dv;
  logic [7:0] din [2];
  logic [1:0] rdy, txo, bsy, fd;

  int n_vec;
  int n_err;
  int acc [2];

  parity_serial_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(bsy[0]), .frame_done(fd[0])
  );

  parity_serial_tx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(bsy[1]), .frame_done(fd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes that will be taken on the coming edge
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!reset && dv[s] && rdy[s]) acc[s] = acc[s] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, wait for acceptance, then check every cycle of the frame and the done cycle.
  task automatic xmit(input int sel, input logic [7:0] b, input logic epar,
                      input logic hold, input logic [7:0] nxt, output int waited);
    int cpb;
    logic [10:0] frame;
    logic p;
    cpb = (sel == 0) ? 4 : 1;
`ifdef PAR_TX_ODD_PARITY_EN
    p = ~epar;
`else
    p = epar;
`endif
    frame = {1'b1, p, b, 1'b0};
    din[sel] = b;
    dv[sel]  = 1'b1;
    waited = 0;
    while (!rdy[sel] && waited < 200) begin
      step();
      waited++;
    end
    if (!rdy[sel]) begin
      check("accept_timeout", 32'(rdy[sel]), 32'd1);
      dv[sel] = 1'b0;
      return;
    end
    step();
    if (hold) din[sel] = nxt;
    else dv[sel] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < cpb; c++) begin
        check("tx_bit", 32'(txo[sel]), 32'(frame[i]));
        check("busy_in_frame", 32'(bsy[sel]), 32'd1);
        check("ready_in_frame", 32'(rdy[sel]), 32'd0);
        check("done_in_frame", 32'(fd[sel]), 32'd0);
        step();
      end
    end
    check("done_pulse", 32'(fd[sel]), 32'd1);
    check("busy_after", 32'(bsy[sel]), 32'd0);
    check("tx_idle_after", 32'(txo[sel]), 32'd1);
    check("ready_after", 32'(rdy[sel]), 32'd1);
  endtask

  initial begin
    int w;
    n_vec = 0;
    n_err = 0;
    acc[0] = 0;
    acc[1] = 0;
    dv = 2'b11;
    din[0] = 8'h55;
    din[1] = 8'h55;
    reset = 1'b1;

    // Reset held 3 cycles with data_valid asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", 32'(txo), 32'h3);
      check("rst_ready", 32'(rdy), 32'h3);
      check("rst_busy", 32'(bsy), 32'h0);
      check("rst_done", 32'(fd), 32'h0);
    end
    dv = 2'b00;
    reset = 1'b0;
    step();
    check("rst_no_accept0", 32'(acc[0]), 32'd0);
    check("rst_no_accept1", 32'(acc[1]), 32'd0);
    check("post_rst_tx", 32'(txo), 32'h3);
    check("post_rst_busy", 32'(bsy), 32'h0);

    // 0xA5 even parity 0; 0x07 even parity 1
    xmit(0, 8'hA5, 1'b0, 1'b0, 8'h00, w);
    step();
    check("done_one_cycle", 32'(fd[0]), 32'd0);
    xmit(0, 8'h07, 1'b1, 1'b0, 8'h00, w);
    step();

    // Back-to-back 0x00 then 0xFF with data_valid held
    acc[0] = 0;
    xmit(0, 8'h00, 1'b0, 1'b1, 8'hFF, w);
    xmit(0, 8'hFF, 1'b0, 1'b0, 8'h00, w);
    check("b2b_gap", 32'(w), 32'd0);
    step();
    check("b2b_accepts", 32'(acc[0]), 32'd2);

    // Reset during data bit 3 of 0x3C
    din[0] = 8'h3C;
    dv[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("pre_abort_busy", 32'(bsy[0]), 32'd1);
    check("pre_abort_bit3", 32'(txo[0]), 32'd1);
    reset = 1'b1;
    step();
    check("abort_tx", 32'(txo[0]), 32'd1);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_ready", 32'(rdy[0]), 32'd1);
    check("abort_done", 32'(fd[0]), 32'd0);
    reset = 1'b0;
    step();
    check("abort_no_done", 32'(fd[0]), 32'd0);
    xmit(0, 8'h3C, 1'b0, 1'b0, 8'h00, w);
    step();

    // One clock per bit, 0x80: parity 1
    xmit(1, 8'h80, 1'b1, 1'b0, 8'h00, w);
    step();
    check("cpb1_idle", 32'(txo[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
